// File: rtl/win_match_fsm.sv
// Window-match detector: after a start pulse, counts ones over back-to-back
// WIN-cycle windows and pulses z when the count satisfies the compare mode.
module win_match_fsm #(
   parameter int unsigned WIN   = 3,
   parameter int unsigned MATCH = 2,
   parameter int unsigned MODE  = 0,
   parameter int unsigned CW    = $clog2(WIN + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s,
   input  logic          w,
   input  logic          clr,
   output logic          z,
   output logic          done,
   output logic [CW-1:0] ones,
   output logic          busy
);

   localparam int unsigned     IW   = (WIN > 1) ? $clog2(WIN) : 1;
   localparam logic [IW-1:0]   LAST = IW'(WIN - 1);
   localparam logic [CW-1:0]   TGT  = CW'(MATCH);

   // One-hot encoding leaves spare codes that the default arm steers back to IDLE.
   typedef enum logic [1:0] {
      IDLE   = 2'b01,
      SAMPLE = 2'b10
   } state_t;

   state_t        state, state_nx;
   logic [IW-1:0] idx, idx_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [CW-1:0] total, ones_nx;
   logic          last, hit, z_nx, done_nx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         idx   <= '0;
         cnt   <= '0;
         z     <= 1'b0;
         done  <= 1'b0;
         ones  <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         cnt   <= cnt_nx;
         z     <= z_nx;
         done  <= done_nx;
         ones  <= ones_nx;
      end
   end

   always_comb begin
      state_nx = IDLE;
      idx_nx   = '0;
      cnt_nx   = '0;
      last     = (idx == LAST);
      total    = cnt + CW'(w);
      if (!clr) begin
         case (state)
            IDLE: begin
               if (s) state_nx = SAMPLE;
            end
            SAMPLE: begin
               state_nx = SAMPLE;
               if (!last) begin
                  idx_nx = idx + IW'(1);
                  cnt_nx = total;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      case (MODE)
         1:       hit = (total >= TGT);
         2:       hit = (total <= TGT);
         default: hit = (total == TGT);
      endcase
      z_nx    = 1'b0;
      done_nx = 1'b0;
      ones_nx = ones;
      // clr discards a window completing on the same edge.
      if (!clr && state == SAMPLE && last) begin
         done_nx = 1'b1;
         z_nx    = hit;
         ones_nx = total;
      end
   end

   assign busy = (state == SAMPLE);

endmodule
